// File: rtl/restador_serial.sv
// rtl/restador_serial.sv - bit-serial full subtractor (in_a - in_b - bin), LSB first
// One subtractor cell, one borrow flop; start/busy/done handshake with held results.
module restador_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             bout_q, bout_d, ovf_q, ovf_d;
    logic             bit_a, bit_b, d_bit, br_next;

    always_comb begin
        bit_a   = a_q[0];
        bit_b   = b_q[0];
        d_bit   = bit_a ^ bit_b ^ br_q;
        br_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & br_q);

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        br_d    = br_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    br_d    = bin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so bit WIDTH-1 lands last in place.
                res_d = {d_bit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = br_next;
                    ovf_d   = (bit_a != bit_b) && (d_bit != bit_a);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            br_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            br_q    <= br_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;
endmodule

// File: doc/restador_serial.md
Name: restador_serial

Overview:
- Bit-serial full subtractor: computes in_a - in_b - bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the inverse-direction companion to the team's full-adder blocks, intended for area-constrained datapaths that already host the serial adder.
- Uses a start/busy/done handshake; results are held stable until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge, accepted only in IDLE.
- in_a  input  WIDTH  minuend (unsigned or two's complement), sampled with accepted start.
- in_b  input  WIDTH  subtrahend, sampled with accepted start.
- bin  input  1  borrow-in, sampled with accepted start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; result registers updated this cycle.
- diff  output  WIDTH  (in_a - in_b - bin) mod 2^WIDTH.
- bout  output  1  unsigned borrow-out: 1 when in_a < in_b + bin.
- ovf  output  1  signed overflow of the subtraction.

Behaviour:
- Reset (rst_n low, any time, asynchronous) sets these values:
  - State = IDLE.
  - busy = 0, done = 0, diff = 0, bout = 0, ovf = 0.
  - Internal operand shift registers, borrow FF and bit counter = 0.
  - Release is synchronous to the next clk edge. Reset mid-RUN aborts the operation with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start = 1, latch in_a, in_b and bin.
  - Set borrow FF = bin, counter = 0, go to RUN.
  - start = 0 stays in IDLE.
- RUN: each edge processes bit i = counter, using a = in_a[i], b = in_b[i], br = borrow FF:
  - d_i = a ^ b ^ br.
  - br_next = (~a & b) | (~(a ^ b) & br).
  - d_i is shifted into an internal result shift register (MSB entry, shifting toward LSB).
  - Operand registers shift right; counter increments.
  - On the edge processing bit WIDTH-1, go to DONE and load the outputs:
    - diff = full shift-register value.
    - bout = final br_next.
    - ovf = (in_a[W-1] != in_b[W-1]) && (d_{W-1} != in_a[W-1]).
- DONE: done = 1 for exactly this cycle; the next edge returns to IDLE unconditionally.
- Latency:
  - With start accepted at edge t, done is high in the cycle following edge t+WIDTH.
  - busy is high from after edge t through the DONE cycle.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- start while busy (RUN or DONE) is ignored: no queuing, no effect on the current operation.
- start held high continuously: a new operation is accepted on the first edge in IDLE after DONE.
- Input changes on in_a, in_b or bin during RUN have no effect; only values latched at acceptance are used.
- diff, bout and ovf change only at the RUN→DONE edge (or reset). Between operations they hold the previous result; intermediate bits are never visible.
- Counter width: clog2(WIDTH) bits; terminal count is WIDTH-1 with no wrap beyond it.
- Arithmetic identity checked by verification: {bout, diff} == (2^WIDTH + in_a - in_b - bin) with bout inverted as borrow.
  - Equivalently: diff == (in_a - in_b - bin) mod 2^WIDTH, and bout == (in_a < in_b + bin).

Test Plan:
- Reset mid-operation: start 0x55 - 0x11, assert rst_n low during the 4th RUN cycle → all outputs 0 immediately, no done pulse; a following start 0x10 - 0x01 → diff = 0x0F, bout = 0, ovf = 0.
- Basic (WIDTH = 8): in_a = 0x3C, in_b = 0x15, bin = 0 → done exactly 8 cycles after the start edge; diff = 0x27, bout = 0, ovf = 0; busy high for 9 cycles.
- Borrow chain: in_a = 0x00, in_b = 0x00, bin = 1 → diff = 0xFF, bout = 1, ovf = 0.
- Signed overflow: in_a = 0x80, in_b = 0x01, bin = 0 → diff = 0x7F, bout = 0, ovf = 1. Then in_a = 0x7F, in_b = 0xFF → diff = 0x80, bout = 1, ovf = 1.
- Start while busy: start pulsed again in RUN cycle 3 and in the DONE cycle with different operands → ignored; diff matches the first operation, single done pulse. Start held high continuously → back-to-back operations every 10 cycles.
- Random regression: 10,000 random in_a, in_b, bin for WIDTH = 8 and WIDTH = 2 → diff, bout and ovf match the reference model; outputs stable between done pulses.
